mem_stage_lsu: RTL and testbench
================================

// Module: mem_stage_lsu
// PURPOSE
// Memory-stage load/store unit; consumes the EX/MEM control/data register outputs.
// Issues one data-bus transaction per load/store (req/gnt, then rvalid for loads) and aligns store data/byte enables.
// Sign/zero-extends load data; stalls the pipeline while an access is in flight; flags misaligned accesses.
// PARAMETERS
// AW        32      bus/address width
// RES_LOAD  3'b001  ResultSrcM code that marks a load (result from memory)
// PORTS
// clk          in   1   clock, rising edge
// reset        in   1   asynchronous, active-low reset
// ALUResultM   in   AW  effective byte address
// WriteDataM   in   32  store data (rs2)
// MemWriteM    in   1   store instruction
// ResultSrcM   in   3   load when == RES_LOAD
// ByteAccessM  in   2   size: 00 byte, 01 half, 10 word, 11 treated as word
// ByteSrcM     in   3   load ext: 000 LW, 001 LB, 010 LH, 011 LBU, 100 LHU, others = LW
// bus_req      out  1   request valid
// bus_we       out  1   1 = write
// bus_addr     out  AW  word-aligned address {ALUResultM[AW-1:2],2'b00}
// bus_wdata    out  32  lane-replicated store data
// bus_be       out  4   byte enables
// bus_gnt      in   1   request accepted this cycle
// bus_rvalid   in   1   read data valid
// bus_rdata    in   32  read data word
// ReadDataM    out  32  extended load result, held until next load completes
// StallM       out  1   freeze IF..MEM while access in flight
// MisalignM    out  1   one-cycle pulse: misaligned access, no bus traffic
// BEHAVIOUR
// access = MemWriteM | (ResultSrcM==RES_LOAD); store has priority if both.
// misaligned = half & addr[0], or word & addr[1:0]!=0.
// FSM IDLE/REQ/RESP/DONE, registered. IDLE: access & !misaligned -> latch we/addr/wdata/be/offset/ext, go REQ.
// REQ: bus_req=1 with latched, stable signals; gnt & we -> DONE; gnt & !we -> RESP.
// RESP: bus_req=0; rvalid -> ReadDataM <= extend(rdata), go DONE. rvalid in REQ/IDLE/DONE ignored.
// DONE: StallM=0 for exactly this cycle (pipeline advances); -> IDLE.
// StallM = (IDLE & access & !misaligned) | REQ | RESP; combinational.
// Misaligned in IDLE: MisalignM=1 (comb), no stall, no req, state stays IDLE.
// Store: byte wdata={4{WD[7:0]}}, be=4'b0001<<addr[1:0]; half wdata={2{WD[15:0]}},
//   be=addr[1]?1100:0011; word wdata=WD, be=1111.
// Load: byte lane rdata[8*off+:8], half lane rdata[16*off[1]+:16]; LB/LH sign-extend, LBU/LHU zero-extend.
// Min latency (gnt first REQ cycle, rvalid next cycle): store 3 cycles stalled 2; load 4 cycles stalled 3.
// Reset (async, active-low): state IDLE; bus_req/bus_we 0, bus_addr/bus_wdata/ReadDataM 0, bus_be 0;
//   a transaction in flight is abandoned, bus_req drops immediately; late rvalid after reset ignored.
// TESTING
// SB addr 0x1003 WD 0x000000A5, gnt immediate -> bus_be 1000, wdata A5A5A5A5, addr 0x1000, StallM 2 cycles.
// LB addr 0x2, rdata 0x00800000 -> ReadDataM 0xFFFFFF80; LBU same -> 0x00000080.
// LHU addr 0x2, rdata 0x80010000 -> 0x00008001; LH -> 0xFFFF8001.
// LW addr 0x6 -> MisalignM high 1 cycle, bus_req 0, StallM 0.
// SW with gnt delayed 3 cycles -> bus_req/addr/wdata/be stable, StallM held until DONE.
// Reset low during RESP -> bus_req 0, StallM 0 at once; rvalid after release has no effect.

Source files
------------

// File: rtl/mem_stage_lsu_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_lsu_if
// Description : Data-bus interface between the memory-stage load/store unit
//               and the data memory / interconnect. A request is issued with
//               bus_req and accepted with bus_gnt; loads are completed later
//               by bus_rvalid carrying bus_rdata.
//
// Signals
//   bus_req     master -> slave   request valid
//   bus_we      master -> slave   1 = write, 0 = read
//   bus_addr    master -> slave   word-aligned byte address (AW bits)
//   bus_wdata   master -> slave   lane-replicated store data
//   bus_be      master -> slave   byte enables
//   bus_gnt     slave  -> master  request accepted this cycle
//   bus_rvalid  slave  -> master  read data valid
//   bus_rdata   slave  -> master  read data word
//
// Revision    : 1.0  initial release
// ============================================================================
interface mem_stage_lsu_if #(
    parameter int AW = 32
);
    logic          bus_req;
    logic          bus_we;
    logic [AW-1:0] bus_addr;
    logic [31:0]   bus_wdata;
    logic [3:0]    bus_be;
    logic          bus_gnt;
    logic          bus_rvalid;
    logic [31:0]   bus_rdata;

    // Load/store unit side
    modport master (
        output bus_req,
        output bus_we,
        output bus_addr,
        output bus_wdata,
        output bus_be,
        input  bus_gnt,
        input  bus_rvalid,
        input  bus_rdata
    );

    // Memory / interconnect side
    modport slave (
        input  bus_req,
        input  bus_we,
        input  bus_addr,
        input  bus_wdata,
        input  bus_be,
        output bus_gnt,
        output bus_rvalid,
        output bus_rdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_stage_lsu.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_lsu
// Description : Memory-stage load/store unit. Takes the EX/MEM register
//               outputs, issues one data-bus transaction per load or store,
//               aligns store data and byte enables, extends load data and
//               stalls the pipeline while an access is in flight. Misaligned
//               accesses are flagged and never reach the bus.
//
// Parameters
//   AW          bus/address width
//   RES_LOAD    ResultSrcM code marking a load
//
// Ports
//   clk          in   1   clock, rising edge
//   reset        in   1   asynchronous, active-low reset
//   ALUResultM   in   AW  effective byte address
//   WriteDataM   in   32  store data
//   MemWriteM    in   1   store instruction
//   ResultSrcM   in   3   load when equal to RES_LOAD
//   ByteAccessM  in   2   size: 00 byte, 01 half, 1x word
//   ByteSrcM     in   3   load extension: 000 LW, 001 LB, 010 LH,
//                         011 LBU, 100 LHU, others LW
//   bus          if   -   data-bus master port (see mem_stage_lsu_if)
//   ReadDataM    out  32  extended load result, held until next load
//   StallM       out  1   freeze IF..MEM while an access is in flight
//   MisalignM    out  1   misaligned access detected (no bus traffic)
//
// Revision    : 1.0  initial release
// ============================================================================
module mem_stage_lsu #(
    parameter int          AW       = 32,
    parameter logic [2:0]  RES_LOAD = 3'b001
) (
    input  wire logic          clk,
    input  wire logic          reset,
    input  wire logic [AW-1:0] ALUResultM,
    input  wire logic [31:0]   WriteDataM,
    input  wire logic          MemWriteM,
    input  wire logic [2:0]    ResultSrcM,
    input  wire logic [1:0]    ByteAccessM,
    input  wire logic [2:0]    ByteSrcM,
    mem_stage_lsu_if.master    bus,
    output logic [31:0]        ReadDataM,
    output logic               StallM,
    output logic               MisalignM
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_REQ  = 2'd1;
    localparam logic [1:0] c_RESP = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    localparam logic [2:0] c_EXT_LB  = 3'b001;
    localparam logic [2:0] c_EXT_LH  = 3'b010;
    localparam logic [2:0] c_EXT_LBU = 3'b011;
    localparam logic [2:0] c_EXT_LHU = 3'b100;

    // ------------------------------------------------------------------
    // State and latched transaction
    // ------------------------------------------------------------------
    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [31:0]   r_wdata;
    logic [3:0]    r_be;
    logic [1:0]    r_off;
    logic [2:0]    r_ext;
    logic [31:0]   r_read_data;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic        w_is_store;
    logic        w_is_load;
    logic        w_access;
    logic        w_half;
    logic        w_word;
    logic        w_misalign;
    logic        w_idle;
    logic        w_start;
    logic [31:0] w_wdata;
    logic [3:0]  w_be;

    // A store wins when both store and load codes are present, so the
    // write flag alone decides the direction.
    assign w_is_store = MemWriteM;
    assign w_is_load  = (ResultSrcM == RES_LOAD);
    assign w_access   = w_is_store | w_is_load;

    // Size code 11 behaves as a word.
    assign w_half     = (ByteAccessM == 2'b01);
    assign w_word     = ByteAccessM[1];
    assign w_misalign = (w_half & ALUResultM[0]) | (w_word & (|ALUResultM[1:0]));

    assign w_idle     = (r_state == c_IDLE);
    assign w_start    = w_idle & w_access & ~w_misalign;

    // Store data is replicated across every lane so the byte enables alone
    // select which bytes memory updates.
    always_comb begin
        w_wdata = WriteDataM;
        w_be    = 4'b1111;
        case (ByteAccessM)
            2'b00: begin
                w_wdata = {4{WriteDataM[7:0]}};
                w_be    = 4'b0001 << ALUResultM[1:0];
            end
            2'b01: begin
                w_wdata = {2{WriteDataM[15:0]}};
                w_be    = ALUResultM[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                w_wdata = WriteDataM;
                w_be    = 4'b1111;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Load data lane select and extension
    // ------------------------------------------------------------------
    function automatic logic [31:0] f_extend(
        input logic [31:0] rdata,
        input logic [1:0]  off,
        input logic [2:0]  ext
    );
        logic [7:0]  v_byte;
        logic [15:0] v_half;
        case (off)
            2'd0:    v_byte = rdata[7:0];
            2'd1:    v_byte = rdata[15:8];
            2'd2:    v_byte = rdata[23:16];
            default: v_byte = rdata[31:24];
        endcase
        v_half = off[1] ? rdata[31:16] : rdata[15:0];
        case (ext)
            c_EXT_LB:  f_extend = {{24{v_byte[7]}}, v_byte};
            c_EXT_LH:  f_extend = {{16{v_half[15]}}, v_half};
            c_EXT_LBU: f_extend = {24'd0, v_byte};
            c_EXT_LHU: f_extend = {16'd0, v_half};
            default:   f_extend = rdata;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Transaction FSM
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_start) begin
                    w_state_nxt = c_REQ;
                end
            end
            c_REQ: begin
                if (bus.bus_gnt) begin
                    w_state_nxt = r_we ? c_DONE : c_RESP;
                end
            end
            c_RESP: begin
                if (bus.bus_rvalid) begin
                    w_state_nxt = c_DONE;
                end
            end
            c_DONE: begin
                w_state_nxt = c_IDLE;
            end
            default: begin
                w_state_nxt = c_IDLE;
            end
        endcase
    end

    // The request is captured on entry to REQ so that bus signals stay
    // stable for however long the slave withholds the grant, even though the
    // EX/MEM inputs are not guaranteed to be stable.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= c_IDLE;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= 32'd0;
            r_be        <= 4'd0;
            r_off       <= 2'd0;
            r_ext       <= 3'd0;
            r_read_data <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            if (w_start) begin
                r_we    <= w_is_store;
                r_addr  <= {ALUResultM[AW-1:2], 2'b00};
                r_wdata <= w_wdata;
                r_be    <= w_be;
                r_off   <= ALUResultM[1:0];
                r_ext   <= ByteSrcM;
            end
            // Read data is accepted only while waiting for it; a stray
            // rvalid in any other state is dropped.
            if ((r_state == c_RESP) && bus.bus_rvalid) begin
                r_read_data <= f_extend(bus.bus_rdata, r_off, r_ext);
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // bus_req decodes directly from the state register so that it falls
    // with the asynchronous reset rather than on the next clock.
    assign bus.bus_req   = (r_state == c_REQ);
    assign bus.bus_we    = r_we;
    assign bus.bus_addr  = r_addr;
    assign bus.bus_wdata = r_wdata;
    assign bus.bus_be    = r_be;

    assign ReadDataM = r_read_data;

    // The stall is raised already in the IDLE cycle that launches the
    // access and is released in DONE so the pipeline moves on exactly once.
    assign StallM    = w_start | (r_state == c_REQ) | (r_state == c_RESP);
    assign MisalignM = w_idle & w_access & w_misalign;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_lsu.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_mem_stage_lsu
// Description : Directed self-checking bench for mem_stage_lsu. The bench
//               plays the bus slave with programmable grant / read-valid
//               delays; expected bus transactions and load results are
//               queued when a step is driven and compared when the DUT
//               produces them.
// Revision    : 1.0  initial release
// ============================================================================
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] ALUResultM = 32'd0;
    logic [31:0] WriteDataM = 32'd0;
    logic        MemWriteM = 1'b0;
    logic [2:0]  ResultSrcM = 3'd0;
    logic [1:0]  ByteAccessM = 2'd0;
    logic [2:0]  ByteSrcM = 3'd0;
    logic [31:0] ReadDataM;
    logic        StallM;
    logic        MisalignM;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        chk_data;
    } bus_txn_t;

    bus_txn_t    bus_q[$];
    logic [31:0] rd_q[$];
    logic [31:0] model_rd = 32'd0;

    always #5 clk = ~clk;

    mem_stage_lsu_if #(.AW(32)) bif ();

    mem_stage_lsu #(
        .AW       (32),
        .RES_LOAD (3'b001)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ALUResultM  (ALUResultM),
        .WriteDataM  (WriteDataM),
        .MemWriteM   (MemWriteM),
        .ResultSrcM  (ResultSrcM),
        .ByteAccessM (ByteAccessM),
        .ByteSrcM    (ByteSrcM),
        .bus         (bif),
        .ReadDataM   (ReadDataM),
        .StallM      (StallM),
        .MisalignM   (MisalignM)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_idle();
        MemWriteM   = 1'b0;
        ResultSrcM  = 3'd0;
        ALUResultM  = 32'd0;
        WriteDataM  = 32'd0;
        ByteAccessM = 2'd0;
        ByteSrcM    = 3'd0;
    endtask

    task automatic drive(input logic [31:0] addr, input logic [31:0] wd, input logic st,
                         input logic ld, input logic [1:0] sz, input logic [2:0] ext);
        ALUResultM  = addr;
        WriteDataM  = wd;
        MemWriteM   = st;
        ResultSrcM  = ld ? 3'b001 : 3'b000;
        ByteAccessM = sz;
        ByteSrcM    = ext;
    endtask

    // Called just after a falling edge. Runs one aligned access to its DONE
    // cycle acting as bus slave, then returns just after the next falling edge.
    task automatic do_access(input string tag, input logic [31:0] addr, input logic [31:0] wd,
                             input logic st, input logic ld, input logic [1:0] sz,
                             input logic [2:0] ext, input int gnt_dly, input int rv_dly,
                             input logic [31:0] rdata, input logic [3:0] exp_be,
                             input logic [31:0] exp_wdata, input int exp_stall,
                             input logic [31:0] exp_rd);
        bus_txn_t t;
        bus_txn_t f;
        int       stalls;
        int       req_n;
        int       resp_n;
        logic     granted;
        logic     in_resp;
        logic     done;
        drive(addr, wd, st, ld, sz, ext);
        t.we       = st;
        t.addr     = {addr[31:2], 2'b00};
        t.wdata    = exp_wdata;
        t.be       = exp_be;
        t.chk_data = st;
        bus_q.push_back(t);
        if (ld && !st) model_rd = exp_rd;
        rd_q.push_back(model_rd);
        f       = t;
        stalls  = 0;
        req_n   = 0;
        resp_n  = 0;
        in_resp = 1'b0;
        done    = 1'b0;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            #1;
            if (StallM !== 1'b1) begin
                done = 1'b1;
            end else begin
                stalls++;
                granted = 1'b0;
                if (bif.bus_req === 1'b1) begin
                    check({tag, " q_nonempty"}, 32'(bus_q.size() != 0), 32'd1);
                    if (bus_q.size() != 0) f = bus_q[0];
                    check({tag, " bus_we"}, 32'(bif.bus_we), 32'(f.we));
                    check({tag, " bus_addr"}, bif.bus_addr, f.addr);
                    if (f.chk_data) begin
                        check({tag, " bus_wdata"}, bif.bus_wdata, f.wdata);
                        check({tag, " bus_be"}, 32'(bif.bus_be), 32'(f.be));
                    end
                    if (req_n == gnt_dly) begin
                        bif.bus_gnt = 1'b1;
                        granted     = 1'b1;
                        if (bus_q.size() != 0) void'(bus_q.pop_front());
                    end
                    req_n++;
                end else if (in_resp) begin
                    if (resp_n == rv_dly) begin
                        bif.bus_rvalid = 1'b1;
                        bif.bus_rdata  = rdata;
                    end
                    resp_n++;
                end
                @(negedge clk);
                bif.bus_gnt    = 1'b0;
                bif.bus_rvalid = 1'b0;
                bif.bus_rdata  = 32'hDEADBEEF;
                if (granted && !f.we) in_resp = 1'b1;
            end
        end
        check({tag, " completed"}, 32'(done), 32'd1);
        check({tag, " stall_cycles"}, 32'(stalls), 32'(exp_stall));
        check({tag, " done_no_req"}, 32'(bif.bus_req), 32'd0);
        check({tag, " bus_q_drained"}, 32'(bus_q.size()), 32'd0);
        check({tag, " ReadDataM"}, ReadDataM, rd_q.pop_front());
        bus_q.delete();
        drive_idle();
        @(negedge clk);
    endtask

    // Called just after a falling edge: a misaligned access must neither stall
    // nor reach the bus, and the FSM must stay idle across the clock edge.
    task automatic do_misalign(input string tag, input logic [31:0] addr, input logic st,
                               input logic ld, input logic [1:0] sz, input logic [2:0] ext);
        drive(addr, 32'h0BAD0BAD, st, ld, sz, ext);
        #1;
        check({tag, " MisalignM"}, 32'(MisalignM), 32'd1);
        check({tag, " StallM"}, 32'(StallM), 32'd0);
        check({tag, " bus_req"}, 32'(bif.bus_req), 32'd0);
        @(negedge clk);
        drive_idle();
        #1;
        check({tag, " MisalignM_pulse_end"}, 32'(MisalignM), 32'd0);
        check({tag, " bus_req_after"}, 32'(bif.bus_req), 32'd0);
        check({tag, " ReadDataM_held"}, ReadDataM, model_rd);
        @(negedge clk);
    endtask

    initial begin
        bif.bus_gnt    = 1'b0;
        bif.bus_rvalid = 1'b0;
        bif.bus_rdata  = 32'hDEADBEEF;
        drive_idle();

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst bus_req", 32'(bif.bus_req), 32'd0);
        check("rst bus_we", 32'(bif.bus_we), 32'd0);
        check("rst bus_addr", bif.bus_addr, 32'd0);
        check("rst bus_wdata", bif.bus_wdata, 32'd0);
        check("rst bus_be", 32'(bif.bus_be), 32'd0);
        check("rst ReadDataM", ReadDataM, 32'd0);
        check("rst StallM", 32'(StallM), 32'd0);
        check("rst MisalignM", 32'(MisalignM), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        // tag, addr, wd, st, ld, sz, ext, gnt_dly, rv_dly, rdata, be, wdata, stalls, rd
        do_access("SB_1003", 32'h1003, 32'h000000A5, 1'b1, 1'b0, 2'b00, 3'b000, 0, 0,
                  32'h0, 4'b1000, 32'hA5A5A5A5, 2, 32'h0);
        do_access("LB_2", 32'h2, 32'h0, 1'b0, 1'b1, 2'b00, 3'b001, 0, 0,
                  32'h00800000, 4'h0, 32'h0, 3, 32'hFFFFFF80);
        do_access("LBU_2", 32'h2, 32'h0, 1'b0, 1'b1, 2'b00, 3'b011, 0, 0,
                  32'h00800000, 4'h0, 32'h0, 3, 32'h00000080);
        do_access("LHU_2", 32'h2, 32'h0, 1'b0, 1'b1, 2'b01, 3'b100, 0, 0,
                  32'h80010000, 4'h0, 32'h0, 3, 32'h00008001);
        do_access("LH_2", 32'h2, 32'h0, 1'b0, 1'b1, 2'b01, 3'b010, 0, 0,
                  32'h80010000, 4'h0, 32'h0, 3, 32'hFFFF8001);

        do_misalign("LW_6", 32'h6, 1'b0, 1'b1, 2'b10, 3'b000);
        do_misalign("LH_1", 32'h1, 1'b0, 1'b1, 2'b01, 3'b010);
        do_misalign("SW_2", 32'h2, 1'b1, 1'b0, 2'b11, 3'b000);

        do_access("SW_gnt3", 32'h40, 32'h12345678, 1'b1, 1'b0, 2'b10, 3'b000, 3, 0,
                  32'h0, 4'b1111, 32'h12345678, 5, 32'h0);
        do_access("SH_22", 32'h22, 32'hBEEFCAFE, 1'b1, 1'b0, 2'b01, 3'b000, 1, 0,
                  32'h0, 4'b1100, 32'hCAFECAFE, 3, 32'h0);
        do_access("SH_20", 32'h20, 32'h0000BEEF, 1'b1, 1'b0, 2'b01, 3'b000, 0, 0,
                  32'h0, 4'b0011, 32'hBEEFBEEF, 2, 32'h0);
        do_access("LW_rv2", 32'h8, 32'h0, 1'b0, 1'b1, 2'b10, 3'b000, 0, 2,
                  32'h11223344, 4'h0, 32'h0, 5, 32'h11223344);
        do_access("LBU_1", 32'h1, 32'h0, 1'b0, 1'b1, 2'b00, 3'b011, 0, 0,
                  32'h0000AB00, 4'h0, 32'h0, 3, 32'h000000AB);
        do_access("LB_3", 32'h3, 32'h0, 1'b0, 1'b1, 2'b00, 3'b001, 1, 1,
                  32'h7F000000, 4'h0, 32'h0, 5, 32'h0000007F);
        do_access("SB_LD_prio", 32'h101, 32'h0000003C, 1'b1, 1'b1, 2'b00, 3'b001, 0, 0,
                  32'h0, 4'b0010, 32'h3C3C3C3C, 2, 32'h0);

        // Reset while waiting for read data
        drive(32'h10, 32'h0, 1'b0, 1'b1, 2'b10, 3'b000);
        #1;
        check("rstmid idle_stall", 32'(StallM), 32'd1);
        @(negedge clk);
        #1;
        check("rstmid req", 32'(bif.bus_req), 32'd1);
        bif.bus_gnt = 1'b1;
        @(negedge clk);
        bif.bus_gnt = 1'b0;
        #1;
        check("rstmid resp_no_req", 32'(bif.bus_req), 32'd0);
        check("rstmid resp_stall", 32'(StallM), 32'd1);
        drive_idle();
        reset = 1'b0;
        model_rd = 32'd0;
        #1;
        check("rstmid bus_req", 32'(bif.bus_req), 32'd0);
        check("rstmid StallM", 32'(StallM), 32'd0);
        check("rstmid ReadDataM", ReadDataM, model_rd);
        @(negedge clk);
        reset = 1'b1;
        bif.bus_rvalid = 1'b1;
        bif.bus_rdata  = 32'hCAFEF00D;
        @(negedge clk);
        bif.bus_rvalid = 1'b0;
        bif.bus_rdata  = 32'hDEADBEEF;
        #1;
        check("late_rvalid ReadDataM", ReadDataM, model_rd);
        check("late_rvalid StallM", 32'(StallM), 32'd0);
        check("late_rvalid bus_req", 32'(bif.bus_req), 32'd0);
        @(negedge clk);

        do_access("LW_after_rst", 32'hC, 32'h0, 1'b0, 1'b1, 2'b10, 3'b000, 0, 0,
                  32'h0BADF00D, 4'h0, 32'h0, 3, 32'h0BADF00D);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
